px_frame_loader: RTL and testbench

- Writer side of the pixel store: accepts one 28x28 image as a serial stream of pixel words over a valid/ready handshake.
- Buffers the words in on-chip memory and presents the completed frame as a parallel array of NUM_PX words, the same shape the neuron layer consumes from the pixel ROM.
- Lets a host or UART front-end load new digits at run time instead of baking them in at elaboration.

---
 rtl/px_frame_loader.sv | 146 ++++++++++++++
 tb/tb_px_frame_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/px_frame_loader.sv
// Streams one NUM_PX-word frame in over valid/ready, holds it until acknowledged.
// Optional running checksum output enabled by defining PX_LOADER_CHECKSUM_EN.
module px_frame_loader #(
   parameter int DATA_W = 32,
   parameter int NUM_PX = 784,
   parameter int CNT_W  = $clog2(NUM_PX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic [DATA_W-1:0] px_data [NUM_PX],
   output logic [CNT_W-1:0]  px_count,
   output logic              err_len
`ifdef PX_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] frame_sum
`endif
);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  px_count_q, px_count_d;
   logic              err_len_q, err_len_d;
   logic              s_ready_q, s_ready_d;
   logic              frame_valid_q, frame_valid_d;
   logic              accept_s;
   logic [DATA_W-1:0] mem_q [NUM_PX];
`ifdef PX_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   assign accept_s = s_valid && s_ready_q;

   // Next-state, counter, error and checksum logic.
   always_comb begin
      state_d    = state_q;
      px_count_d = px_count_q;
      err_len_d  = err_len_q;
`ifdef PX_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      case (state_q)
         FILL: begin
            if (accept_s) begin
`ifdef PX_LOADER_CHECKSUM_EN
               sum_d = sum_q + s_data;
`endif
               if (px_count_q == LAST_IDX) begin
                  // Final slot: frame is presented whether or not s_last came with it.
                  state_d    = FULL;
                  px_count_d = px_count_q + CNT_ONE;
                  if (!s_last) begin
                     err_len_d = 1'b1;
                  end else begin
                     err_len_d = err_len_q;
                  end
               end else if (s_last) begin
                  err_len_d  = 1'b1;
                  px_count_d = CNT_ZERO;
`ifdef PX_LOADER_CHECKSUM_EN
                  sum_d      = {DATA_W{1'b0}};
`endif
               end else begin
                  px_count_d = px_count_q + CNT_ONE;
               end
            end else begin
               px_count_d = px_count_q;
            end
         end
         FULL: begin
            if (frame_ack) begin
               state_d    = FILL;
               px_count_d = CNT_ZERO;
`ifdef PX_LOADER_CHECKSUM_EN
               sum_d      = {DATA_W{1'b0}};
`endif
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d    = FILL;
            px_count_d = CNT_ZERO;
         end
      endcase
      s_ready_d     = (state_d == FILL);
      frame_valid_d = (state_d == FULL);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         px_count_q    <= CNT_ZERO;
         err_len_q     <= 1'b0;
         s_ready_q     <= 1'b1;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         px_count_q    <= px_count_d;
         err_len_q     <= err_len_d;
         s_ready_q     <= s_ready_d;
         frame_valid_q <= frame_valid_d;
      end
   end

`ifdef PX_LOADER_CHECKSUM_EN
   // Running checksum register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= {DATA_W{1'b0}};
      end else begin
         sum_q <= sum_d;
      end
   end

   assign frame_sum = sum_q;
`endif

   // Pixel storage; intentionally not reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_q[px_count_q] <= s_data;
      end
   end

   assign px_data     = mem_q;
   assign s_ready     = s_ready_q;
   assign frame_valid = frame_valid_q;
   assign px_count    = px_count_q;
   assign err_len     = err_len_q;

endmodule

// File: tb/tb_px_frame_loader.sv
// Directed self-checking bench for px_frame_loader.
module tb_px_frame_loader;

   localparam int DATA_W = 32;
   localparam int NUM_PX = 784;
   localparam int CNT_W  = 10;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              frame_valid;
   logic              frame_ack;
   logic [DATA_W-1:0] px_data [NUM_PX];
   logic [CNT_W-1:0]  px_count;
   logic              err_len;
`ifdef PX_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] frame_sum;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int fv_rises = 0;
   logic fv_prev = 1'b0;

   px_frame_loader #(.DATA_W(DATA_W), .NUM_PX(NUM_PX), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .px_data     (px_data),
      .px_count    (px_count),
      .err_len     (err_len)
`ifdef PX_LOADER_CHECKSUM_EN
      ,
      .frame_sum   (frame_sum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts rising edges of frame_valid.
   always @(posedge clk) begin
      fv_prev <= frame_valid;
      if (frame_valid && !fv_prev) fv_rises <= fv_rises + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int kind, input int i);
      case (kind)
         0:       pat = 32'(i);
         1:       pat = 32'hA5A50000 + 32'(i);
         default: pat = 32'd1000 + 32'(i);
      endcase
   endfunction

   task automatic send_word(input logic [31:0] d, input logic l, input int gap);
      int guard;
      for (int g = 0; g < gap; g++) begin
         frame_ack = 1'b1;
         @(posedge clk); #1;
      end
      frame_ack = 1'b0;
      s_valid = 1'b1; s_data = d; s_last = l;
      guard = 0;
      while (!s_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;
   endtask

   task automatic send_range(input int kind, input int first, input int n, input int last_at,
                             input int gapmax);
      for (int i = first; i < first + n; i++) begin
         send_word(pat(kind, i), (i == last_at), (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
      end
   endtask

   task automatic check_frame(input string tag, input int kind);
      int bad = 0;
      for (int i = 0; i < NUM_PX; i++) begin
         if (px_data[i] !== pat(kind, i)) bad++;
      end
      check(tag, 64'(bad), 64'd0);
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
   endtask

   initial begin
      int rises0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; frame_ack = 1'b0;
      #22;
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_px_count", 64'(px_count), 64'd0);
      check("rst_err_len", 64'(err_len), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Normal frame
      send_range(0, 0, NUM_PX - 1, NUM_PX - 1, 0);
      check("norm_fv_before_last", 64'(frame_valid), 64'd0);
      check("norm_count_783", 64'(px_count), 64'd783);
      send_range(0, NUM_PX - 1, 1, NUM_PX - 1, 0);
      check("norm_fv", 64'(frame_valid), 64'd1);
      check("norm_ready", 64'(s_ready), 64'd0);
      check("norm_err", 64'(err_len), 64'd0);
      check("norm_count", 64'(px_count), 64'd784);
      repeat (10) @(posedge clk);
      #1;
      check("norm_fv_held", 64'(frame_valid), 64'd1);
      check_frame("norm_px_data", 0);
`ifdef PX_LOADER_CHECKSUM_EN
      check("norm_sum", 64'(frame_sum), 64'd306936);
`endif

      // Backpressure and ack
      s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("bp_count", 64'(px_count), 64'd784);
      check("bp_px0", 64'(px_data[0]), 64'd0);
      pulse_ack();
      check("ack_fv", 64'(frame_valid), 64'd0);
      check("ack_ready", 64'(s_ready), 64'd1);
      check("ack_count", 64'(px_count), 64'd0);
      check("ack_px0_old", 64'(px_data[0]), 64'd0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("ack_px0_new", 64'(px_data[0]), 64'hDEADBEEF);
      check("ack_count1", 64'(px_count), 64'd1);

      // Async reset mid-fill after 300 words
      send_range(0, 1, 299, -1, 0);
      check("mid_count300", 64'(px_count), 64'd300);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(s_ready), 64'd1);
      check("mid_rst_fv", 64'(frame_valid), 64'd0);
      check("mid_rst_count", 64'(px_count), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Short frame then correct frame
      send_range(1, 0, 100, 99, 0);
      check("short_err", 64'(err_len), 64'd1);
      check("short_count", 64'(px_count), 64'd0);
      check("short_fv", 64'(frame_valid), 64'd0);
      send_range(1, 0, NUM_PX, NUM_PX - 1, 0);
      check("after_short_fv", 64'(frame_valid), 64'd1);
      check("after_short_err", 64'(err_len), 64'd1);
      check_frame("after_short_px", 1);
`ifdef PX_LOADER_CHECKSUM_EN
      check("after_short_sum", 64'(frame_sum), 64'(32'hA5A50000 * 32'd784 + 32'd306936));
`endif

      // Async reset while FULL
      #3 rst_n = 1'b0;
      #1;
      check("full_rst_fv", 64'(frame_valid), 64'd0);
      check("full_rst_err", 64'(err_len), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Long frame (no s_last)
      send_range(2, 0, NUM_PX, -1, 0);
      check("long_fv", 64'(frame_valid), 64'd1);
      check("long_err", 64'(err_len), 64'd1);
      check("long_ready", 64'(s_ready), 64'd0);
      check_frame("long_px", 2);
      s_valid = 1'b1; s_data = 32'h12345678;
      repeat (2) @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("long_trunc_count", 64'(px_count), 64'd784);
      check("long_trunc_px0", 64'(px_data[0]), 64'd1000);
      pulse_ack();

      // Gapped valid with ignored acks in FILL
      rises0 = fv_rises;
      send_range(0, 0, NUM_PX, NUM_PX - 1, 5);
      repeat (5) @(posedge clk);
      #1;
      check("gap_fv", 64'(frame_valid), 64'd1);
      check("gap_rises", 64'(fv_rises - rises0), 64'd1);
      check_frame("gap_px", 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
